// File: rtl/bmc_pkg.sv
// Shared helpers and puncture-pattern constants for the branch-metric unit.
package bmc_pkg;

  localparam int         PUNC_LEN_R23 = 2;
  localparam logic [3:0] PUNC_PAT_R23 = 4'b0111;
  localparam int         PUNC_LEN_R34 = 3;
  localparam logic [5:0] PUNC_PAT_R34 = 6'b100111;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width that holds the worst-case sum of N_OUT maximal soft distances.
  function automatic int bm_width(input int n_out, input int soft_w);
    return clog2(n_out * ((1 << soft_w) - 1) + 1);
  endfunction

endpackage

// File: rtl/bmc_bit_dist.sv
// Per-code-bit distances to an expected '0' (d0) and '1' (d1).
// Combinational; erased bits contribute nothing to either hypothesis.
module bmc_bit_dist #(
  parameter int SOFT_W = 3
) (
  input  logic [SOFT_W-1:0] soft_i,
  input  logic              hard_i,
  input  logic              erase_i,
  output logic [SOFT_W-1:0] d0_o,
  output logic [SOFT_W-1:0] d1_o
);

  localparam logic [SOFT_W-1:0] MAXV = '1;

  always_comb begin
    d0_o = '0;
    d1_o = '0;
    if (!erase_i) begin
      if (hard_i) begin
        d0_o[0] = soft_i[SOFT_W-1];
        d1_o[0] = ~soft_i[SOFT_W-1];
      end else begin
        d0_o = soft_i;
        d1_o = MAXV - soft_i;
      end
    end
  end

endmodule

// File: rtl/bmc_soft_pipe.sv
// Branch metrics for all 2^N_OUT hypotheses with depuncturing; 2-cycle latency.
// Valid/ready pipeline, 1 beat/cycle; each stage holds under downstream stall.
module bmc_soft_pipe
  import bmc_pkg::*;
#(
  parameter int                        N_OUT    = 2,
  parameter int                        SOFT_W   = 3,
  parameter int                        PUNC_LEN = 1,
  parameter logic [PUNC_LEN*N_OUT-1:0] PUNC_PAT = '1,
  localparam int                       BM_W     = bm_width(N_OUT, SOFT_W)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_OUT*SOFT_W-1:0]       rx_sym,
  input  logic                          hard_mode,
  input  logic                          punct_en,
  input  logic                          blk_start,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(1<<N_OUT)*BM_W-1:0]    bm_out,
  output logic [N_OUT-1:0]              out_erase
);

  localparam int              NH      = 1 << N_OUT;
  localparam int              PH_W    = (PUNC_LEN > 1) ? clog2(PUNC_LEN) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PUNC_LEN - 1);

  logic                         adv1, adv2, accept;
  logic                         s1_valid_q, out_valid_q;
  logic [PH_W-1:0]              phase_q, phase_used, phase_d;
  logic [N_OUT-1:0]             erase_d, s1_erase_q, out_erase_q;
  logic [N_OUT-1:0][SOFT_W-1:0] d0_d, d1_d, s1_d0_q, s1_d1_q;
  logic [NH*BM_W-1:0]           bm_d, bm_q;

  assign adv2     = ~out_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;
  assign accept   = in_valid & adv1;

  // blk_start realigns the pattern to phase 0 for the beat that carries it.
  assign phase_used = blk_start ? '0 : phase_q;
  assign phase_d    = (phase_used == PH_LAST) ? '0 : phase_used + 1'b1;
  assign erase_d    = punct_en ? ~PUNC_PAT[phase_used*N_OUT +: N_OUT] : '0;

  for (genvar i = 0; i < N_OUT; i++) begin : g_bit
    bmc_bit_dist #(.SOFT_W(SOFT_W)) u_dist (
      .soft_i  (rx_sym[i*SOFT_W +: SOFT_W]),
      .hard_i  (hard_mode),
      .erase_i (erase_d[i]),
      .d0_o    (d0_d[i]),
      .d1_o    (d1_d[i])
    );
  end

  always_comb begin
    logic [BM_W-1:0] acc;
    acc  = '0;
    bm_d = '0;
    for (int h = 0; h < NH; h++) begin
      acc = '0;
      for (int i = 0; i < N_OUT; i++) begin
        acc = acc + BM_W'(h[i] ? s1_d1_q[i] : s1_d0_q[i]);
      end
      bm_d[h*BM_W +: BM_W] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_d0_q     <= '0;
      s1_d1_q     <= '0;
      s1_erase_q  <= '0;
      out_valid_q <= 1'b0;
      bm_q        <= '0;
      out_erase_q <= '0;
    end else begin
      if (adv1) s1_valid_q <= in_valid;
      if (accept) begin
        phase_q    <= phase_d;
        s1_d0_q    <= d0_d;
        s1_d1_q    <= d1_d;
        s1_erase_q <= erase_d;
      end
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          bm_q        <= bm_d;
          out_erase_q <= s1_erase_q;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign bm_out    = bm_q;
  assign out_erase = out_erase_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe at N_OUT=2, SOFT_W=3 with the rate-3/4 puncture pattern.
module tb_bmc_soft_pipe;
  import bmc_pkg::*;

  localparam int         N_OUT  = 2;
  localparam int         SOFT_W = 3;
  localparam int         PLEN   = PUNC_LEN_R34;
  localparam logic [5:0] PAT    = PUNC_PAT_R34;
  localparam int         BM_W   = 4;
  localparam int         NH     = 4;
  localparam int         M      = 7;

  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready;
  logic [5:0]  rx_sym = '0;
  logic        hard_mode = 0, punct_en = 0, blk_start = 0;
  logic        out_valid, out_ready = 0;
  logic [15:0] bm_out;
  logic [1:0]  out_erase;

  typedef struct packed {
    logic [15:0] bm;
    logic [1:0]  er;
  } res_t;

  res_t exp_q[$], got_q[$];
  int   model_phase = 0, pu = 0, ov_run = 0, ov_max = 0;
  int   checks = 0, errors = 0;

  bmc_soft_pipe #(.N_OUT(N_OUT), .SOFT_W(SOFT_W), .PUNC_LEN(PLEN), .PUNC_PAT(PAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .rx_sym(rx_sym),
    .hard_mode(hard_mode), .punct_en(punct_en), .blk_start(blk_start),
    .out_valid(out_valid), .out_ready(out_ready), .bm_out(bm_out), .out_erase(out_erase)
  );

  always #5 clk = ~clk;

  // Metric = distance of each kept received bit from the hypothesised code bit.
  function automatic res_t model(input logic [5:0] sym, input logic hard, input logic pe, input int ph);
    res_t r;
    logic [5:0] pat;
    int s, b, sum;
    pat = PAT;
    r = '0;
    for (int i = 0; i < N_OUT; i++) r.er[i] = pe && !pat[ph*N_OUT+i];
    for (int h = 0; h < NH; h++) begin
      sum = 0;
      for (int i = 0; i < N_OUT; i++) begin
        if (!r.er[i]) begin
          s = int'(sym[i*SOFT_W +: SOFT_W]);
          b = (h >> i) & 1;
          if (hard) sum += (((s >= (M + 1) / 2) ? 1 : 0) != b) ? 1 : 0;
          else      sum += b ? (M - s) : s;
        end
      end
      r.bm[h*BM_W +: BM_W] = 4'(sum);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      got_q.delete();
      model_phase = 0;
      ov_run = 0;
    end else begin
      ov_run = out_valid ? ov_run + 1 : 0;
      if (ov_run > ov_max) ov_max = ov_run;
      if (out_valid && out_ready) got_q.push_back(res_t'({bm_out, out_erase}));
      if (in_valid && in_ready) begin
        pu = blk_start ? 0 : model_phase;
        exp_q.push_back(model(rx_sym, hard_mode, punct_en, pu));
        model_phase = (pu + 1) % PLEN;
      end
    end
  end

  task automatic send(input logic [5:0] sym, input logic hard, input logic pe, input logic blk, output bit ok);
    in_valid = 1; rx_sym = sym; hard_mode = hard; punct_en = pe; blk_start = blk; ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0; blk_start = 0;
  endtask

  task automatic drain();
    in_valid = 0; blk_start = 0; out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (bm_out !== 16'h0) begin errors++; $display("FAIL rst_bm got %h want 0000", bm_out); end
    checks++; if (out_erase !== 2'b00) begin errors++; $display("FAIL rst_erase got %b want 00", out_erase); end
    rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_hard_basic();
    res_t r, e;
    out_ready = 1;
    in_valid = 1; rx_sym = 6'b111_000; hard_mode = 1; punct_en = 0; blk_start = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t1_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_latency got %b want 1", out_valid); end
    checks++; if (bm_out !== 16'h1021) begin errors++; $display("FAIL t1_bm got %h want 1021", bm_out); end
    checks++; if (out_erase !== 2'b00) begin errors++; $display("FAIL t1_erase got %b want 00", out_erase); end
    @(posedge clk); #1;
    drain();
    checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL t1_count got %0d want 1 (model %0d)", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL t1_beat got bm=%h er=%b want bm=%h er=%b", r.bm, r.er, e.bm, e.er); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    bit ok, all_ok;
    int k;
    all_ok = 1;
    out_ready = 1;
    ov_max = 0;
    send(6'b101_010, 0, 0, 0, ok); all_ok &= ok;
    for (int b = 1; b < 8; b++) begin
      send(6'($urandom), 0, 0, 0, ok); all_ok &= ok;
    end
    drain();
    checks++; if (!all_ok) begin errors++; $display("FAIL t2_accept got stalled want accepted"); end
    checks++; if (ov_max != 8) begin errors++; $display("FAIL t2_consecutive got %0d want 8", ov_max); end
    checks++; if (got_q.size() != 8 || exp_q.size() != 8) begin errors++; $display("FAIL t2_count got %0d want 8 (model %0d)", got_q.size(), exp_q.size()); end
    k = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front(); e = exp_q.pop_front();
      if (k == 0) begin
        checks++; if (r.bm !== 16'h74A7) begin errors++; $display("FAIL t2_soft_first got %h want 74a7", r.bm); end
      end
      checks++; if (r !== e) begin errors++; $display("FAIL t2_beat%0d got bm=%h er=%b want bm=%h er=%b", k, r.bm, r.er, e.bm, e.er); end
      k++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    res_t r, e;
    logic [5:0] syms [4];
    int acc_cnt;
    for (int b = 0; b < 4; b++) syms[b] = 6'($urandom);
    acc_cnt = 0;
    out_ready = 0; hard_mode = 0; punct_en = 0; blk_start = 0;
    in_valid = 1; rx_sym = syms[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) acc_cnt++;
      @(posedge clk); #1;
      if (acc_cnt < 4) rx_sym = syms[acc_cnt];
    end
    checks++; if (acc_cnt != 2) begin errors++; $display("FAIL t3_accepts_stalled got %0d want 2", acc_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t3_in_ready got %b want 0", in_ready); end
    out_ready = 1;
    for (int c = 0; c < 20 && acc_cnt < 4; c++) begin
      @(negedge clk);
      if (in_ready) acc_cnt++;
      @(posedge clk); #1;
      if (acc_cnt < 4) rx_sym = syms[acc_cnt];
    end
    in_valid = 0;
    drain();
    checks++; if (got_q.size() != 4 || exp_q.size() != 4) begin errors++; $display("FAIL t3_count got %0d want 4 (model %0d)", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL t3_beat got bm=%h er=%b want bm=%h er=%b", r.bm, r.er, e.bm, e.er); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_phase();
    res_t r, e;
    bit ok, all_ok;
    int k;
    logic [1:0] er_want [7];
    er_want = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
    all_ok = 1;
    out_ready = 1;
    send(6'b111_000, 0, 1, 1, ok); all_ok &= ok;
    send(6'b111_000, 0, 1, 0, ok); all_ok &= ok;
    send(6'($urandom), 1'($urandom), 1, 1, ok); all_ok &= ok;
    send(6'($urandom), 1'($urandom), 1, 0, ok); all_ok &= ok;
    drain();
    out_ready = 0;
    send(6'b111_000, 0, 1, 0, ok); all_ok &= ok;
    send(6'($urandom), 0, 1, 0, ok); all_ok &= ok;
    in_valid = 1; blk_start = 1; punct_en = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t5_stall_ready got %b want 0", in_ready); end
    in_valid = 0; blk_start = 0; out_ready = 1;
    drain();
    send(6'($urandom), 0, 1, 0, ok); all_ok &= ok;
    drain();
    checks++; if (!all_ok) begin errors++; $display("FAIL t5_accept got stalled want accepted"); end
    checks++; if (got_q.size() != 7 || exp_q.size() != 7) begin errors++; $display("FAIL t5_count got %0d want 7 (model %0d)", got_q.size(), exp_q.size()); end
    k = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front(); e = exp_q.pop_front();
      if (k < 7) begin
        checks++; if (r.er !== er_want[k]) begin errors++; $display("FAIL t5_erase%0d got %b want %b", k, r.er, er_want[k]); end
      end
      if (k == 1) begin
        checks++; if (r.bm !== 16'h7070) begin errors++; $display("FAIL t5_ph1_bm got %h want 7070", r.bm); end
      end
      if (k == 4) begin
        checks++; if (r.bm !== 16'h0077) begin errors++; $display("FAIL t5_ph2_bm got %h want 0077", r.bm); end
      end
      checks++; if (r !== e) begin errors++; $display("FAIL t5_beat%0d got bm=%h er=%b want bm=%h er=%b", k, r.bm, r.er, e.bm, e.er); end
      k++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midstream();
    res_t r, e;
    bit ok, all_ok;
    int k;
    all_ok = 1;
    out_ready = 1;
    send(6'($urandom), 0, 1, 1, ok); all_ok &= ok;
    send(6'($urandom), 0, 1, 0, ok); all_ok &= ok;
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_valid got %b want 0", out_valid); end
    checks++; if (bm_out !== 16'h0) begin errors++; $display("FAIL t6_bm got %h want 0000", bm_out); end
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    send(6'($urandom), 1'($urandom), 1, 0, ok); all_ok &= ok;
    send(6'($urandom), 1'($urandom), 1, 0, ok); all_ok &= ok;
    drain();
    checks++; if (!all_ok) begin errors++; $display("FAIL t6_accept got stalled want accepted"); end
    checks++; if (got_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL t6_count got %0d want 2 (model %0d)", got_q.size(), exp_q.size()); end
    k = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front(); e = exp_q.pop_front();
      if (k == 0) begin
        checks++; if (r.er !== 2'b00) begin errors++; $display("FAIL t6_first_phase got %b want 00", r.er); end
      end
      checks++; if (r !== e) begin errors++; $display("FAIL t6_beat%0d got bm=%h er=%b want bm=%h er=%b", k, r.bm, r.er, e.bm, e.er); end
      k++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    res_t r, e;
    int n;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      rx_sym    = 6'($urandom);
      hard_mode = 1'($urandom_range(0, 1));
      punct_en  = 1'($urandom_range(0, 1));
      blk_start = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();
    n = exp_q.size();
    checks++; if (got_q.size() != n || n == 0) begin errors++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), n); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL rnd_beat got bm=%h er=%b want bm=%h er=%b", r.bm, r.er, e.bm, e.er); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_hard_basic();
    test_back_to_back();
    test_backpressure();
    test_phase();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmc_soft_pipe.md
Name: bmc_soft_pipe

Overview:
Parametrised branch-metric unit for the Viterbi decoder front end. It is the successor to the fixed rate-1/2 hard-decision BMC cells. For each received symbol of N_OUT code bits, it computes the metric against all 2^N_OUT code-word hypotheses in one pass. It supports soft-decision or hard-decision per beat, plus depuncturing through a built-in pattern phase counter. It sits between the symbol input buffer and the ACS array, with a 2-stage valid/ready pipeline.

Parameters:
N_OUT, 2, code bits per trellis step (1/N_OUT mother code); legal 2..4
SOFT_W, 3, soft-bit width; 0 = strongest '0', 2^SOFT_W-1 = strongest '1'
PUNC_LEN, 1, puncture period in symbols; 1..8
PUNC_PAT, all ones, PUNC_LEN*N_OUT bits; bit [p*N_OUT+i] = 1 keeps code bit i in phase p, 0 marks it erased
BM_W, clog2(N_OUT*(2^SOFT_W-1)+1), metric width (derived, localparam; 4 for defaults)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
rx_sym  in  N_OUT*SOFT_W  soft bit i at [i*SOFT_W +: SOFT_W]
hard_mode  in  1  1 = hard decision, using only the MSB of each soft bit; sampled per beat
punct_en  in  1  1 = apply PUNC_PAT; 0 = no erasures; sampled per beat
blk_start  in  1  accepted beat is phase 0 of the puncture pattern
out_valid  out  1  metrics valid
out_ready  in  1  downstream accepts
bm_out  out  (2^N_OUT)*BM_W  metric for hypothesis h at [h*BM_W +: BM_W]; bit i of h is expected code bit i
out_erase  out  N_OUT  erasure mask applied to this beat

Behaviour:
- Reset (asynchronous assert, synchronous release): out_valid=0, internal stage-1 valid=0, bm_out=0, out_erase=0, phase=0. in_ready is combinational and reads 1 after reset.
- Handshake:
  - Accept when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - adv2 = ~out_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1.
  - No combinational path from in_valid to in_ready.
- Latency: exactly 2 cycles from acceptance to out_valid with no stall. Full throughput of 1 beat/cycle with out_ready held high.
- Under stall, all held registers keep their values. No beat is lost or duplicated, and order is preserved.
- Stage 1 (registered): per code bit i, with s = rx_sym bit i and M = 2^SOFT_W-1:
  - Soft: d0 = s, d1 = M-s.
  - Hard: d0 = s[MSB], d1 = ~s[MSB].
  - Erased bit: d0 = d1 = 0.
  - Registered together with the erase mask.
- Stage 2 (registered): bm[h] = sum over i of (h[i] ? d1_i : d0_i), unsigned and zero-extended to BM_W. Overflow is impossible by construction.
- Puncture phase counter (0..PUNC_LEN-1):
  - Erase mask = ~PUNC_PAT[phase_used*N_OUT +: N_OUT] when punct_en=1, else 0.
  - phase_used = 0 if blk_start=1 on the accepted beat, else the current phase.
  - On each accepted beat: phase <= (phase_used+1) mod PUNC_LEN.
  - The counter advances only on accepted beats. blk_start without acceptance is ignored.
  - With PUNC_LEN=1, phase stays at 0.
- hard_mode, punct_en and blk_start travel with their own beat. Changing them between beats affects only the new beat.
- Reset mid-stream discards in-flight beats. The first accepted beat after reset uses phase 0.

Decomposition:
- Package bmc_pkg: function clog2, the metric-width function, and the default puncture patterns as constants (rate 2/3 = 4'b0111 with PUNC_LEN 2; rate 3/4 = 6'b100111 with PUNC_LEN 3).
- Sub-module bmc_bit_dist: combinational per-bit (d0, d1) from soft value, mode and erase. Instantiated N_OUT times in stage 1.

Test Plan:
1. Hard mode, defaults, rx_sym = {s1=7, s0=0}, punct_en=0 -> after 2 cycles bm = {h3=1, h2=0, h1=2, h0=1}, out_erase=00.
2. Soft mode, s0=2, s1=5 -> bm h0=7, h1=10, h2=4, h3=7; back-to-back 8 beats with out_ready=1 give 8 consecutive out_valid cycles.
3. Backpressure: 4 beats offered, out_ready=0 for 5 cycles -> in_ready falls after 2 accepts; after release, all 4 emerge in order with correct metrics and no duplicates.
4. PUNC_LEN=3, PUNC_PAT=6'b100111, punct_en=1, blk_start on beat 0, soft s0=0, s1=7 each beat:
   - phase 1 (erase=10) -> h0=0, h1=7, h2=0, h3=7.
   - phase 2 (erase=01) -> h0=7, h1=7, h2=0, h3=0.
   - beat 3 returns to phase 0.
5. blk_start asserted on the accepted beat while phase=2 -> that beat uses the phase-0 mask (00) and the next beat uses phase 1. blk_start asserted while in_ready=0 -> no phase change.
6. rst_n pulsed low with 2 beats in flight -> out_valid=0 and bm_out=0 immediately. After release, the first accepted beat uses phase 0.
